ctrl_sequencer: RTL and testbench

Multi-cycle control sequencer: the consumer of the 11-bit main-decoder control word. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables and memory request handshakes from that word. It also raises exceptions for illegal opcodes and memory timeouts, and counts retired instructions. It sits between the main decoder and the multi-cycle datapath (PC, IR, register file, memories).

---
 rtl/ctrl_pkg.sv | 48 ++++
 rtl/ctrl_sequencer_wait_timer.sv | 25 ++
 rtl/ctrl_sequencer.sv | 173 +++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control path: control-word bit positions,
// sequencer state codes, PC source select and exception cause values.
package ctrl_pkg;

  localparam int CW_W       = 11;
  localparam int CW_JUMP    = 10;
  localparam int CW_BRANCH  = 9;
  localparam int CW_MEM_RD  = 8;
  localparam int CW_MEM_WR  = 7;
  localparam int CW_MEM2REG = 6;
  localparam int CW_ALUOP_H = 5;
  localparam int CW_ALUOP_L = 4;
  localparam int CW_EXC     = 3;
  localparam int CW_ALU_SRC = 2;
  localparam int CW_REG_WR  = 1;
  localparam int CW_REG_DST = 0;

  localparam logic [1:0] ALUOP_HALF = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_EXC    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_EXC    = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'b00,
    EXC_ILLEGAL = 2'b01,
    EXC_IMEM_TO = 2'b10,
    EXC_DMEM_TO = 2'b11
  } exc_cause_e;

  // alu_op of 11 on a memory access selects a halfword transfer
  function automatic logic is_half(input logic [CW_W-1:0] cw);
    return cw[CW_ALUOP_H:CW_ALUOP_L] == ALUOP_HALF;
  endfunction

endpackage

// File: rtl/ctrl_sequencer_wait_timer.sv
// Memory wait counter. o_tc is high during the TIMEOUT-th consecutive wait cycle,
// so the sequencer can abandon the request on that same edge.
module wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + W'(1);
  end

  assign o_tc = (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXEC/MEM/WB from the
// decoder control word, drives datapath strobes, raises exceptions, counts retires.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [10:0]      ctrl_word,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             exc_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             dmem_half,
  output logic             rf_we,
  output logic             exc_valid,
  output logic [1:0]       exc_cause,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  state_e           r_state, w_state_nxt;
  logic [CW_W-1:0]  r_ctrl_q;
  logic [1:0]       r_cause, w_cause_nxt;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire, w_wait_en, w_clr, w_tc;
  logic             w_imem_req, w_ir_we, w_pc_we, w_dmem_req;
  logic             w_dmem_we, w_dmem_half, w_rf_we, w_exc_valid;
  logic [1:0]       w_pc_sel;
  logic             w_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_ctrl_q  <= '0;
      r_cause   <= EXC_NONE;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
      if (r_state == S_DECODE) r_ctrl_q  <= ctrl_word;
      if (w_retire)            r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_retire    = 1'b0;
    w_wait_en   = 1'b0;
    w_imem_req  = 1'b0;
    w_ir_we     = 1'b0;
    w_pc_we     = 1'b0;
    w_pc_sel    = PC_PLUS4;
    w_dmem_req  = 1'b0;
    w_dmem_we   = 1'b0;
    w_dmem_half = 1'b0;
    w_rf_we     = 1'b0;
    w_exc_valid = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ready) begin
          w_ir_we     = 1'b1;
          w_pc_we     = 1'b1;
          w_state_nxt = S_DECODE;
        end else begin
          w_wait_en = 1'b1;
          if (w_tc) begin
            w_state_nxt = S_EXC;
            w_cause_nxt = EXC_IMEM_TO;
          end
        end
      end
      // ctrl_q is not loaded yet, so DECODE steers from the live word
      S_DECODE: begin
        if (ctrl_word[CW_EXC]) begin
          w_state_nxt = S_EXC;
          w_cause_nxt = EXC_ILLEGAL;
        end else if (ctrl_word[CW_JUMP]) begin
          w_pc_we     = 1'b1;
          w_pc_sel    = PC_JUMP;
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_ctrl_q[CW_BRANCH]) begin
          w_pc_we     = alu_zero;
          w_pc_sel    = PC_BRANCH;
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (r_ctrl_q[CW_MEM_RD] || r_ctrl_q[CW_MEM_WR]) begin
          w_state_nxt = S_MEM;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_MEM: begin
        w_dmem_req  = 1'b1;
        w_dmem_we   = r_ctrl_q[CW_MEM_WR];
        w_dmem_half = is_half(r_ctrl_q);
        if (dmem_ready) begin
          if (r_ctrl_q[CW_MEM_WR]) begin
            w_retire    = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WB;
          end
        end else begin
          w_wait_en = 1'b1;
          if (w_tc) begin
            w_state_nxt = S_EXC;
            w_cause_nxt = EXC_DMEM_TO;
          end
        end
      end
      S_WB: begin
        w_rf_we     = r_ctrl_q[CW_REG_WR];
        w_retire    = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_EXC: begin
        w_exc_valid = 1'b1;
        if (exc_ack) begin
          w_pc_we     = 1'b1;
          w_pc_sel    = PC_EXC;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Any state change restarts the wait count, so FETCH and MEM always enter at zero
  assign w_clr = (w_state_nxt != r_state);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_en  (w_wait_en),
    .o_tc  (w_tc)
  );

  // Reset must kill requests and strobes immediately, not at the next edge
  assign imem_req  = rst_n & w_imem_req;
  assign ir_we     = rst_n & w_ir_we;
  assign pc_we     = rst_n & w_pc_we;
  assign pc_sel    = rst_n ? w_pc_sel : PC_PLUS4;
  assign dmem_req  = rst_n & w_dmem_req;
  assign dmem_we   = rst_n & w_dmem_we;
  assign dmem_half = rst_n & w_dmem_half;
  assign rf_we     = rst_n & w_rf_we;
  assign exc_valid = rst_n & w_exc_valid;
  assign exc_cause = (rst_n && r_state == S_EXC) ? r_cause : EXC_NONE;
  assign retired   = r_retired;
  assign state     = r_state;

  assign w_unused = &{1'b0, r_ctrl_q[CW_JUMP], r_ctrl_q[CW_EXC], r_ctrl_q[CW_MEM2REG],
                      r_ctrl_q[CW_ALU_SRC], r_ctrl_q[CW_REG_DST]};

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: per-instruction vector table expanded
// into a per-cycle expected-output scoreboard, plus hand sequences for reset and wrap.
module tb_ctrl_sequencer;

  localparam int TO = 16;
  localparam int CW = 4;
  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_X = 3'd5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [10:0]   ctrl_word;
  logic          alu_zero, imem_ready, dmem_ready, exc_ack;
  logic          imem_req, ir_we, pc_we, dmem_req, dmem_we, dmem_half, rf_we, exc_valid;
  logic [1:0]    pc_sel, exc_cause;
  logic [CW-1:0] retired;
  logic [2:0]    state;

  ctrl_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_word(ctrl_word), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .exc_ack(exc_ack),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_half(dmem_half), .rf_we(rf_we),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          imem_req, ir_we, pc_we;
    logic [1:0]    pc_sel;
    logic          dmem_req, dmem_we, dmem_half, rf_we, exc_valid;
    logic [1:0]    exc_cause;
    logic [2:0]    state;
    logic [CW-1:0] retired;
  } obs_t;

  typedef struct {
    string       nm;
    logic [10:0] cw;
    logic        az;
    int          iw, dw, ackw;
    logic        nz;
    int          cycles, ret;
  } vec_t;

  obs_t          sb[$];
  vec_t          tbl[14];
  int            n_chk = 0, n_pass = 0;
  int            len = 0, tb_ret = 0;
  logic [2:0]    prev_st = 3'd7;
  logic [CW-1:0] exp_ret = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = '{imem_req, ir_we, pc_we, pc_sel, dmem_req, dmem_we, dmem_half, rf_we,
          exc_valid, exc_cause, state, retired};
    return o;
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.state = st;
    o.retired = exp_ret;
    return o;
  endfunction

  task automatic drive(input logic ir, input logic dr, input logic ack, input logic az,
                       input logic [10:0] cw);
    imem_ready = ir; dmem_ready = dr; exc_ack = ack; alu_zero = az; ctrl_word = cw;
  endtask

  // Expected output of this cycle goes in with the stimulus; compared mid-cycle.
  task automatic cyc(input obs_t e);
    obs_t a, x;
    sb.push_back(e);
    @(negedge clk);
    a = sample();
    x = sb.pop_front();
    chk($sformatf("cycle st%0d", x.state), 32'(a), 32'(x));
    if (a.state == S_F && prev_st != S_F) len = 1;
    else len++;
    prev_st = a.state;
    @(posedge clk); #1;
  endtask

  task automatic exc_phase(input logic [1:0] cause, input int ackw, input logic nz,
                           input logic [10:0] jk);
    obs_t e;
    for (int k = 0; k < ackw; k++) begin
      drive(nz, nz, 1'b0, 1'b0, jk);
      e = base(S_X); e.exc_valid = 1'b1; e.exc_cause = cause;
      cyc(e);
    end
    drive(nz, nz, 1'b1, 1'b0, jk);
    e = base(S_X); e.exc_valid = 1'b1; e.exc_cause = cause; e.pc_we = 1'b1; e.pc_sel = 2'b11;
    cyc(e);
  endtask

  task automatic run_instr(input vec_t v);
    obs_t e;
    logic [10:0] jk;
    jk = ~v.cw;
    for (int k = 0; k < v.iw && k < TO; k++) begin
      drive(1'b0, v.nz, v.nz, 1'b0, jk);
      e = base(S_F); e.imem_req = 1'b1;
      cyc(e);
    end
    if (v.iw >= TO) begin exc_phase(2'b10, v.ackw, v.nz, jk); return; end
    drive(1'b1, v.nz, v.nz, 1'b0, jk);
    e = base(S_F); e.imem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    cyc(e);
    drive(v.nz, v.nz, v.nz, 1'b0, v.cw);
    e = base(S_D);
    if (v.cw[3]) begin cyc(e); exc_phase(2'b01, v.ackw, v.nz, jk); return; end
    if (v.cw[10]) begin
      e.pc_we = 1'b1; e.pc_sel = 2'b10;
      cyc(e); exp_ret++;
      return;
    end
    cyc(e);
    drive(v.nz, v.nz, v.nz, v.az, jk);
    e = base(S_E);
    if (v.cw[9]) begin
      e.pc_we = v.az; e.pc_sel = 2'b01;
      cyc(e); exp_ret++;
      return;
    end
    cyc(e);
    if (v.cw[8] || v.cw[7]) begin
      for (int k = 0; k < v.dw && k < TO; k++) begin
        drive(v.nz, 1'b0, v.nz, 1'b0, jk);
        e = base(S_M); e.dmem_req = 1'b1; e.dmem_we = v.cw[7]; e.dmem_half = (v.cw[5:4] == 2'b11);
        cyc(e);
      end
      if (v.dw >= TO) begin exc_phase(2'b11, v.ackw, v.nz, jk); return; end
      drive(v.nz, 1'b1, v.nz, 1'b0, jk);
      e = base(S_M); e.dmem_req = 1'b1; e.dmem_we = v.cw[7]; e.dmem_half = (v.cw[5:4] == 2'b11);
      cyc(e);
      if (v.cw[7]) begin exp_ret++; return; end
    end
    drive(v.nz, v.nz, v.nz, 1'b0, jk);
    e = base(S_W); e.rf_we = v.cw[1];
    cyc(e); exp_ret++;
  endtask

  task automatic run_and_check(input vec_t v);
    run_instr(v);
    tb_ret += v.ret;
    chk({v.nm, " back_in_fetch"}, 32'(state), 32'(S_F));
    chk({v.nm, " cycles"}, 32'(len), 32'(v.cycles));
    chk({v.nm, " retired"}, 32'(retired), 32'(tb_ret % (1 << CW)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t e;
    //          name              cw       az    iw  dw  ack  nz    cyc ret
    tbl[0]  = '{"rtype",         11'h023, 1'b0, 0,  0,  0,   1'b0, 4,  1};
    tbl[1]  = '{"lh_wait3",      11'h176, 1'b0, 0,  2,  0,   1'b0, 7,  1};
    tbl[2]  = '{"beq_taken",     11'h210, 1'b1, 0,  0,  0,   1'b0, 3,  1};
    tbl[3]  = '{"beq_nottaken",  11'h210, 1'b0, 0,  0,  0,   1'b0, 3,  1};
    tbl[4]  = '{"illegal",       11'h008, 1'b0, 0,  0,  4,   1'b0, 7,  0};
    tbl[5]  = '{"jump",          11'h400, 1'b0, 0,  0,  0,   1'b0, 2,  1};
    tbl[6]  = '{"sh_iwait",      11'h0B4, 1'b0, 2,  0,  0,   1'b0, 6,  1};
    tbl[7]  = '{"imem_timeout",  11'h023, 1'b0, 16, 0,  0,   1'b0, 17, 0};
    tbl[8]  = '{"imem_rdy_at_tc",11'h023, 1'b0, 15, 0,  0,   1'b0, 19, 1};
    tbl[9]  = '{"dmem_timeout",  11'h176, 1'b0, 0,  16, 1,   1'b0, 21, 0};
    tbl[10] = '{"addi_noise",    11'h006, 1'b0, 0,  0,  0,   1'b1, 4,  1};
    tbl[11] = '{"lw",            11'h146, 1'b0, 0,  0,  0,   1'b0, 5,  1};
    tbl[12] = '{"rtype_nowr_nz", 11'h020, 1'b0, 0,  0,  0,   1'b1, 4,  1};
    tbl[13] = '{"jump_nz_iwait", 11'h400, 1'b0, 1,  0,  0,   1'b1, 3,  1};

    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 11'h7FF);
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(sample()), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) run_and_check(tbl[i]);

    while (exp_ret != 4'hF) run_and_check(tbl[5]);
    chk("retired_all_ones", 32'(retired), 32'hF);
    run_and_check(tbl[5]);
    chk("retired_wrap", 32'(retired), 32'h0);

    run_and_check(tbl[0]);
    chk("pre_rst_retired", 32'(retired), 32'h1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 11'h7FB);
    e = base(S_F); e.imem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    cyc(e);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 11'h084);
    cyc(base(S_D));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 11'h7FB);
    cyc(base(S_E));
    e = base(S_M); e.dmem_req = 1'b1; e.dmem_we = 1'b1;
    cyc(e);
    chk("mem_req_before_rst", 32'(dmem_req), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_dmem_req", 32'(dmem_req), 32'h0);
    chk("rst_state", 32'(state), 32'(S_F));
    chk("rst_retired", 32'(retired), 32'h0);
    chk("rst_all_outputs", 32'(sample()), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ret = '0; tb_ret = 0; prev_st = 3'd7;
    run_and_check(tbl[1]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
